// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: op encodings, exception codes and FSM states shared by the memory access unit.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_W  = 3'd0,
        OP_H  = 3'd1,
        OP_B  = 3'd2,
        OP_HU = 3'd3,
        OP_BU = 3'd4,
        OP_D  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_BUS  = 5'd7;

    // Access size in bytes; 0 marks an op that cannot be issued on this bus width.
    function automatic logic [3:0] op_size(input logic [2:0] op, input logic wide);
        return op == OP_W ? 4'd4 :
               op == OP_H || op == OP_HU ? 4'd2 :
               op == OP_B || op == OP_BU ? 4'd1 :
               op == OP_D && wide ? 4'd8 : 4'd0;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: selects the addressed lane of bus read data and sign/zero-extends it per load op.
module mem_load_ext
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                  op,
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W-1:0]           data
);

    logic [DATA_W-1:0] s;

    always_comb begin
        s = rdata >> {lane, 3'b000};
        data = op == OP_W  ? DATA_W'($signed(s[31:0])) :
               op == OP_H  ? DATA_W'($signed(s[15:0])) :
               op == OP_B  ? DATA_W'($signed(s[7:0])) :
               op == OP_HU ? DATA_W'(s[15:0]) :
               op == OP_BU ? DATA_W'(s[7:0]) :
               op == OP_D  ? s : '0;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit; checks alignment, drives one bus transfer with timeout,
// and returns extended load data or an exception as a one-cycle completion pulse.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [2:0]          req_op,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                int_req,
    output logic                bus_valid,
    output logic [31:0]         bus_addr,
    output logic [DATA_W/8-1:0] bus_byteen,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ready,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stall,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                exc_valid,
    output logic [4:0]          exc_code
);

    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);

    state_e            state, state_n;
    logic [7:0]        cnt;
    logic [2:0]        op_q;
    logic [LW-1:0]     lane_q;
    logic              write_q;
    logic [3:0]        size;
    logic [LW-1:0]     lane;
    logic [NB-1:0]     mask;
    logic              accept, aligned, timed_out;
    logic [DATA_W-1:0] ext;

    always_comb begin
        size = op_size(req_op, DATA_W == 64);
        lane = addr[LW-1:0];
        aligned = size != 4'd0 && (addr[3:0] & (size - 4'd1)) == 4'd0;
        mask = NB'((9'd1 << size) - 9'd1) << lane;
        accept = state == IDLE && req_valid && !int_req;
        timed_out = cnt == 8'(TIMEOUT - 1);
        stall = accept || state == BUSY;
        state_n = state == IDLE ? (accept ? (aligned ? BUSY : DONE) : IDLE) :
                  state == BUSY ? (bus_ready || timed_out ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            op_q       <= '0;
            lane_q     <= '0;
            write_q    <= 1'b0;
            bus_valid  <= 1'b0;
            bus_addr   <= '0;
            bus_byteen <= '0;
            bus_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            exc_valid  <= 1'b0;
            exc_code   <= '0;
        end else begin
            rsp_valid <= state_n == DONE;
            rsp_rdata <= '0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
            if (accept) begin
                bus_valid  <= aligned;
                bus_addr   <= {addr[31:LW], LW'(0)};
                bus_byteen <= mask;
                bus_wdata  <= wdata << {lane, 3'b000};
                op_q       <= req_op;
                lane_q     <= lane;
                write_q    <= req_write;
                cnt        <= '0;
                exc_valid  <= !aligned;
                exc_code   <= aligned ? 5'd0 : req_write ? EXC_ADES : EXC_ADEL;
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
                if (bus_ready || timed_out)
                    bus_valid <= 1'b0;
                // A ready arriving on the timeout cycle still completes the transfer.
                if (bus_ready) begin
                    rsp_rdata <= write_q ? '0 : ext;
                end else if (timed_out) begin
                    exc_valid <= 1'b1;
                    exc_code  <= EXC_BUS;
                end
            end
        end
    end

    mem_load_ext #(.DATA_W(DATA_W)) u_ext (
        .op   (op_q),
        .lane (lane_q),
        .rdata(bus_rdata),
        .data (ext)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit at 32- and 64-bit bus widths
// against a byte-arithmetic reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        rv32 = 1'b0, rv64 = 1'b0, req_write = 1'b0, int_req = 1'b0, bus_ready = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0, bus_rdata = '0;

    logic        bv32, st32, rs32, ex32, bv64, st64, rs64, ex64;
    logic [31:0] ba32, ba64, bwd32, rd32;
    logic [3:0]  be32;
    logic [7:0]  be64;
    logic [63:0] bwd64, rd64;
    logic [4:0]  ec32, ec64;

    logic [63:0] o_bv, o_st, o_rs, o_ex, o_ec, o_ba, o_be, o_wd, o_rd;
    logic        sel = 1'b0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .TIMEOUT(TO)) u32 (
        .clk(clk), .reset(reset), .req_valid(rv32), .req_write(req_write), .req_op(req_op),
        .addr(addr), .wdata(wdata[31:0]), .int_req(int_req), .bus_valid(bv32), .bus_addr(ba32),
        .bus_byteen(be32), .bus_wdata(bwd32), .bus_ready(bus_ready), .bus_rdata(bus_rdata[31:0]),
        .stall(st32), .rsp_valid(rs32), .rsp_rdata(rd32), .exc_valid(ex32), .exc_code(ec32)
    );

    mem_access_unit #(.DATA_W(64), .TIMEOUT(TO)) u64 (
        .clk(clk), .reset(reset), .req_valid(rv64), .req_write(req_write), .req_op(req_op),
        .addr(addr), .wdata(wdata), .int_req(int_req), .bus_valid(bv64), .bus_addr(ba64),
        .bus_byteen(be64), .bus_wdata(bwd64), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .stall(st64), .rsp_valid(rs64), .rsp_rdata(rd64), .exc_valid(ex64), .exc_code(ec64)
    );

    assign o_bv = 64'(sel ? bv64 : bv32);
    assign o_st = 64'(sel ? st64 : st32);
    assign o_rs = 64'(sel ? rs64 : rs32);
    assign o_ex = 64'(sel ? ex64 : ex32);
    assign o_ec = 64'(sel ? ec64 : ec32);
    assign o_ba = 64'(sel ? ba64 : ba32);
    assign o_be = sel ? 64'(be64) : 64'(be32);
    assign o_wd = sel ? bwd64 : 64'(bwd32);
    assign o_rd = sel ? rd64 : 64'(rd32);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bus_valid"}, o_bv, 64'd0);
        chk({tag, "_rsp_valid"}, o_rs, 64'd0);
        chk({tag, "_exc_valid"}, o_ex, 64'd0);
        chk({tag, "_stall"}, o_st, 64'd0);
        chk({tag, "_rsp_rdata"}, o_rd, 64'd0);
    endtask

    function automatic int op_bytes(input bit w64, input logic [2:0] op);
        case (op)
            3'd0:       return 4;
            3'd1, 3'd3: return 2;
            3'd2, 3'd4: return 1;
            3'd5:       return w64 ? 8 : 0;
            default:    return 0;
        endcase
    endfunction

    // One access from an idle unit; k is the bus-wait cycle that sees bus_ready (0 = never).
    task automatic xact(input bit w64, input bit wr, input logic [2:0] op, input logic [31:0] a,
                        input logic [63:0] wd, input logic [63:0] rd, input int k);
        int n, lane;
        bit bad;
        logic [63:0] m, mm, v, e_be, e_wd, e_rd, e_ba;
        n = op_bytes(w64, op);
        lane = int'(a[2:0]) & (w64 ? 7 : 3);
        bad = n == 0 || (int'(a[3:0]) % n) != 0;
        m = w64 ? '1 : 64'hFFFF_FFFF;
        e_ba = 64'(a & (w64 ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC));
        e_be = ((64'd1 << n) - 64'd1) << lane;
        e_wd = (wd << (8 * lane)) & m;
        v = (rd & m) >> (8 * lane);
        mm = n == 8 ? '1 : (64'd1 << (8 * n)) - 64'd1;
        v = v & mm;
        if (!bad && op <= 3'd2 && v[8 * n - 1])
            v = v | ~mm;
        e_rd = (wr || k == 0) ? 64'd0 : v & m;
        @(negedge clk);
        sel = w64;
        #1;
        chk("idle_rsp_valid", o_rs, 64'd0);
        chk("idle_bus_valid", o_bv, 64'd0);
        rv32 = !w64;
        rv64 = w64;
        req_write = wr;
        req_op = op;
        addr = a;
        wdata = wd;
        #1 chk("accept_stall", o_st, 64'd1);
        @(negedge clk);
        rv32 = 1'b0;
        rv64 = 1'b0;
        wdata = {$urandom, $urandom};
        addr = $urandom;
        if (bad) begin
            chk("mis_bus_valid", o_bv, 64'd0);
            chk("mis_rsp_valid", o_rs, 64'd1);
            chk("mis_exc_valid", o_ex, 64'd1);
            chk("mis_exc_code", o_ec, wr ? 64'd5 : 64'd4);
            chk("mis_stall", o_st, 64'd0);
            chk("mis_rsp_rdata", o_rd, 64'd0);
            return;
        end
        for (int c = 1; c <= TO; c++) begin
            chk("busy_bus_valid", o_bv, 64'd1);
            chk("busy_stall", o_st, 64'd1);
            chk("busy_rsp_valid", o_rs, 64'd0);
            chk("bus_addr", o_ba, e_ba);
            chk("bus_byteen", o_be, e_be);
            if (wr)
                chk("bus_wdata", o_wd, e_wd);
            int_req = 1'($urandom_range(0, 1));
            if (c == k) begin
                bus_ready = 1'b1;
                bus_rdata = rd;
            end
            @(negedge clk);
            bus_ready = 1'b0;
            bus_rdata = {$urandom, $urandom};
            if (c == k)
                break;
        end
        int_req = 1'b0;
        chk("done_rsp_valid", o_rs, 64'd1);
        chk("done_stall", o_st, 64'd0);
        chk("done_bus_valid", o_bv, 64'd0);
        chk("done_exc_valid", o_ex, 64'(k == 0));
        chk("done_exc_code", o_ec, k == 0 ? 64'd7 : 64'd0);
        chk("done_rsp_rdata", o_rd, e_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk_quiet("reset");
            chk("reset_bus_addr", o_ba, 64'd0);
            chk("reset_bus_byteen", o_be, 64'd0);
            chk("reset_bus_wdata", o_wd, 64'd0);
            chk("reset_exc_code", o_ec, 64'd0);
        end
        reset = 1'b0;

        xact(1'b0, 1'b1, 3'd2, 32'h1003, 64'hAB, 64'd0, 2);
        xact(1'b0, 1'b0, 3'd1, 32'h2002, 64'd0, 64'h8001_1234, 1);
        xact(1'b0, 1'b0, 3'd3, 32'h2002, 64'd0, 64'h8001_1234, 3);
        xact(1'b0, 1'b1, 3'd0, 32'h0006, 64'h1234, 64'd0, 1);
        xact(1'b0, 1'b0, 3'd0, 32'h0100, 64'd0, 64'd0, 0);
        xact(1'b0, 1'b0, 3'd0, 32'h0104, 64'd0, 64'hDEAD_BEEF, TO);
        xact(1'b0, 1'b0, 3'd6, 32'h0000, 64'd0, 64'd0, 1);
        xact(1'b0, 1'b1, 3'd5, 32'h0008, 64'd5, 64'd0, 1);
        xact(1'b0, 1'b1, 3'd1, 32'h0012, 64'hBEEF, 64'd0, 1);
        xact(1'b1, 1'b0, 3'd5, 32'h0008, 64'd0, 64'h8123_4567_89AB_CDEF, 1);
        xact(1'b1, 1'b1, 3'd5, 32'h0004, 64'd1, 64'd0, 1);
        xact(1'b1, 1'b0, 3'd0, 32'h0004, 64'd0, 64'h8000_0000_1234_5678, 2);
        xact(1'b1, 1'b1, 3'd2, 32'h0017, 64'h5A, 64'd0, 1);
        xact(1'b1, 1'b0, 3'd4, 32'h0017, 64'd0, 64'hF100_0000_0000_0000, 1);
        xact(1'b1, 1'b0, 3'd7, 32'h0000, 64'd0, 64'd0, 1);

        @(negedge clk);
        sel = 1'b0;
        rv32 = 1'b1;
        int_req = 1'b1;
        req_op = 3'd0;
        addr = 32'h40;
        #1 chk("int_block_stall", o_st, 64'd0);
        @(negedge clk);
        chk_quiet("int_block");
        rv32 = 1'b0;
        int_req = 1'b0;

        bus_ready = 1'b1;
        bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bus_ready = 1'b0;
        chk_quiet("stray_ready");

        rv32 = 1'b1;
        req_write = 1'b0;
        req_op = 3'd0;
        addr = 32'h80;
        @(negedge clk);
        rv32 = 1'b0;
        chk("rst_busy_bus_valid", o_bv, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_quiet("rst_busy");
        @(negedge clk);
        chk_quiet("rst_after");

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0)
                a[2:0] = 3'd0;
            xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                 {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, TO));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, bus data width; legal values 32 or 64.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum bus-wait cycles before bus error; legal range 2..255.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  M-stage memory access present.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_op  in  3  access op: 0 W, 1 H, 2 B, 3 HU, 4 BU, 5 D (D legal only when DATA_W=64); 6 and 7 are illegal.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  DATA_W  store data, right-aligned.
REQ-010 int_req  in  1  interrupt pending; blocks acceptance of a new access.
REQ-011 bus_valid / bus_addr / bus_byteen / bus_wdata  out  1/32/DATA_W/8/DATA_W  bus request; registered.
REQ-012 bus_ready  in  1  bus completes the transfer this cycle.
REQ-013 bus_rdata  in  DATA_W  read data, sampled when bus_ready=1.
REQ-014 stall  out  1  hold the pipeline.
REQ-015 rsp_valid / rsp_rdata  out  1/DATA_W  completion pulse / extended load data.
REQ-016 exc_valid / exc_code  out  1/5  exception pulse / code: 4 AdEL, 5 AdES, 7 bus error.

Function
REQ-017 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-018 In IDLE, when req_valid=1 and int_req=0, the unit SHALL accept the access that cycle, drive stall=1, and check alignment.
REQ-019 Alignment SHALL require addr mod size = 0, with size 8/4/2/1 for D/W/H-HU/B-BU; an illegal op SHALL be treated as misaligned.
REQ-020 An aligned access SHALL move to BUSY; bus_valid SHALL be 1 from the next cycle, with bus_addr = addr with the low log2(DATA_W/8) bits cleared.
REQ-021 On a misaligned access the unit SHALL move to DONE without asserting bus_valid, with exc_code = 4 for a load and 5 for a store.
REQ-022 bus_byteen SHALL have contiguous ones of width size, starting at lane addr[log2(DATA_W/8)-1:0]; bus_wdata SHALL be wdata shifted left by 8 times that lane offset; for loads, bus_byteen SHALL be the same mask.
REQ-023 In BUSY, bus outputs SHALL be held stable and stall SHALL be 1; on bus_ready=1 the unit SHALL capture bus_rdata and move to DONE.
REQ-024 An 8-bit cycle counter SHALL clear on entry to BUSY; if TIMEOUT cycles elapse without bus_ready, the unit SHALL drop bus_valid and move to DONE with exc_code = 7.
REQ-025 In DONE, rsp_valid SHALL be 1 and stall SHALL be 0; exc_valid SHALL be 1 only for a faulted access; the next state SHALL be IDLE unconditionally; no acceptance SHALL occur in DONE.
REQ-026 rsp_rdata SHALL be the selected lane shifted right: sign-extended for H/B, zero-extended for HU/BU, the full 32 bits for W (sign-extended to 64 when DATA_W=64), and the full width for D; it SHALL be 0 for stores and exceptions.
REQ-027 Latency: accept at T, bus_valid from T+1, bus_ready at T+k, rsp_valid at T+k+1; a misaligned access SHALL give rsp_valid at T+1.
REQ-028 int_req SHALL block acceptance in IDLE only (no bus activity, no exception, stall=0); it SHALL NOT abort a BUSY transfer.
REQ-029 If bus_ready coincides with the timeout cycle, bus_ready SHALL win.
REQ-030 bus_ready received while bus_valid=0 SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE and clear the counter, and all outputs SHALL be 0 in the following cycle.
REQ-032 A reset during BUSY SHALL drop bus_valid and produce no rsp_valid or exc_valid.

Structure
REQ-033 A shared package SHALL hold the op encodings, exception codes 4/5/7, and the FSM state encoding.
REQ-034 Lane extraction and extension SHALL be implemented in a combinational sub-module, mem_load_ext, parametrised by DATA_W.

Verification
REQ-035 DATA_W=32, SB addr=0x1003, wdata=0xAB, bus_ready at T+2 -> bus_byteen=1000, bus_wdata=0xAB000000, rsp_valid at T+3.
REQ-036 LH addr=0x2002, bus_rdata=0x8001xxxx -> rsp_rdata=0xFFFF8001; LHU with the same data -> 0x00008001.
REQ-037 SW addr=0x0006 -> no bus_valid, rsp_valid and exc_valid at T+1, exc_code=5.
REQ-038 TIMEOUT=4, LW with bus_ready held 0 -> bus_valid for 4 cycles, then exc_code=7.
REQ-039 int_req=1 with req_valid -> no bus_valid and stall=0; reset asserted in BUSY -> bus_valid=0 next cycle and no rsp_valid.
REQ-040 DATA_W=64, LD addr=0x08 -> bus_byteen=0xFF; SD addr=0x04 -> exc_code=5; LW addr=0x04 with bus_rdata[63:32]=0x80000000 -> rsp_rdata=0xFFFFFFFF80000000.
